// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter feeding the address decoder.
// A hold counter bounds ownership under contention so neither master starves.
module bus_arbiter #(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic [7:0]        m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_wr,
    input  logic              m1_req,
    input  logic [7:0]        m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_wr,
    output logic              m0_grant,
    output logic              m1_grant,
    output logic [7:0]        bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_wr,
    output logic              bus_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic        last_grant_r;
    logic        last_grant_nxt_s;
    logic [7:0]  hold_cnt_r;
    logic [7:0]  hold_cnt_nxt_s;

    // State, fairness pointer and hold counter registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            hold_cnt_r   <= 8'd0;
        end else begin
            state_r      <= state_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            hold_cnt_r   <= hold_cnt_nxt_s;
        end
    end

    // Next-state arbitration: release, direct handover and preemption
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_nxt_s = last_grant_r ? GNT0 : GNT1;
                end else if (m0_req) begin
                    state_nxt_s = GNT0;
                end else if (m1_req) begin
                    state_nxt_s = GNT1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GNT0: begin
                if (!m0_req) begin
                    state_nxt_s = m1_req ? GNT1 : IDLE;
                end else if (m1_req && (hold_cnt_r == HOLD_LAST)) begin
                    state_nxt_s = GNT1;
                end else begin
                    state_nxt_s = GNT0;
                end
            end
            GNT1: begin
                if (!m1_req) begin
                    state_nxt_s = m0_req ? GNT0 : IDLE;
                end else if (m0_req && (hold_cnt_r == HOLD_LAST)) begin
                    state_nxt_s = GNT0;
                end else begin
                    state_nxt_s = GNT1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Hold counter restarts on each new grant and saturates while ownership continues
    always_comb begin
        last_grant_nxt_s = last_grant_r;
        hold_cnt_nxt_s   = 8'd0;
        if ((state_nxt_s == GNT0) && (state_r != GNT0)) begin
            last_grant_nxt_s = 1'b0;
            hold_cnt_nxt_s   = 8'd0;
        end else if ((state_nxt_s == GNT1) && (state_r != GNT1)) begin
            last_grant_nxt_s = 1'b1;
            hold_cnt_nxt_s   = 8'd0;
        end else if (state_nxt_s != IDLE) begin
            hold_cnt_nxt_s = (hold_cnt_r == HOLD_LAST) ? hold_cnt_r : hold_cnt_r + 8'd1;
        end else begin
            hold_cnt_nxt_s = 8'd0;
        end
    end

    // Shared bus mux selected by the registered owner; master fields pass straight through
    always_comb begin
        bus_addr  = 8'd0;
        bus_wdata = '0;
        bus_wr    = 1'b0;
        case (state_r)
            GNT0: begin
                bus_addr  = m0_addr;
                bus_wdata = m0_wdata;
                bus_wr    = m0_wr;
            end
            GNT1: begin
                bus_addr  = m1_addr;
                bus_wdata = m1_wdata;
                bus_wr    = m1_wr;
            end
            default: begin
                bus_addr  = 8'd0;
                bus_wdata = '0;
                bus_wr    = 1'b0;
            end
        endcase
    end

    assign m0_grant = (state_r == GNT0);
    assign m1_grant = (state_r == GNT1);
    assign bus_busy = m0_grant | m1_grant;

endmodule
